// File: rtl/strela_pc_pkg.sv
// Shared types for the STRELA elastic processing cell: configuration word and ALU opcodes.
// Struct field widths follow PC_DATA_WIDTH / PC_NUM_PORTS; the cell's parameters must match them.
package strela_pc_pkg;

  localparam int PC_DATA_WIDTH = 32;
  localparam int PC_NUM_PORTS  = 4;
  // Path selectors need one extra code (NUM_PORTS) for the constant operand.
  localparam int PC_SEL_W      = $clog2(PC_NUM_PORTS + 1);
  localparam int PC_ITER_W     = 16;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_MUL   = 4'd2,
    ALU_AND   = 4'd3,
    ALU_OR    = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SLL   = 4'd6,
    ALU_SRL   = 4'd7,
    ALU_SRA   = 4'd8,
    ALU_LT    = 4'd9,
    ALU_MUX   = 4'd10,
    ALU_PASS1 = 4'd11
  } alu_op_e;

  typedef struct packed {
    logic [PC_SEL_W-1:0]      sel_1;
    logic [PC_SEL_W-1:0]      sel_2;
    logic [PC_SEL_W-1:0]      sel_c;
    logic                     use_cin;
    alu_op_e                  alu_op;
    logic [PC_NUM_PORTS-1:0]  fork_mask;
    logic                     acc;
    logic                     initial_valid;
    logic [PC_DATA_WIDTH-1:0] initial_data;
    logic [PC_DATA_WIDTH-1:0] const_data;
    logic [PC_ITER_W-1:0]     iter_count;
  } pc_cfg_t;

endpackage

// File: rtl/strela_fifo.sv
// Operand FIFO for one cell path: power-of-two depth, registered full/empty flags.
// Caller guarantees push only when !full and pop only when !empty.
module strela_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  full,
  output logic                  empty
);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [AW:0]           count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/strela_pc_elastic.sv
// N-port CGRA processing cell: FIFO operand paths, join/ALU, eager fork, iteration limit.
// Define STRELA_PC_ACC_EN to build accumulate mode (cfg.acc replaces operand 2 by an accumulator).
module strela_pc_elastic
  import strela_pc_pkg::*;
#(
  parameter int DATA_WIDTH = PC_DATA_WIDTH,
  parameter int NUM_PORTS  = PC_NUM_PORTS,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] din,
  input  logic [NUM_PORTS-1:0]            din_v,
  output logic [NUM_PORTS-1:0]            din_r,
  output logic [DATA_WIDTH-1:0]           dout,
  output logic [NUM_PORTS-1:0]            dout_v,
  input  logic [NUM_PORTS-1:0]            dout_r,
  input  pc_cfg_t                         cfg,
  input  logic                            enable,
  output logic                            done
);
  localparam int SH_W = $clog2(DATA_WIDTH);

  logic                  clear;
  logic                  acc_mode;
  logic                  sel1_port, sel2_port, selc_port;
  logic                  v_in1, v_in2, v_c, bit_c;
  logic [DATA_WIDTH-1:0] d_in1, d_in2;
  logic                  push1, push2, full1, full2, empty1, empty2;
  logic [DATA_WIDTH-1:0] head1, head2, op1, op2, res;
  logic                  op1_v, op2_v, cin_v, cin;
  logic                  fire, retire, room;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic [NUM_PORTS-1:0]  sent, hs;
  logic [PC_ITER_W-1:0]  iter_cnt;
  logic [PC_ITER_W:0]    in_flight;

  assign clear     = rst || !enable;
  assign sel1_port = cfg.sel_1 < PC_SEL_W'(NUM_PORTS);
  assign sel2_port = cfg.sel_2 < PC_SEL_W'(NUM_PORTS);
  assign selc_port = cfg.sel_c < PC_SEL_W'(NUM_PORTS);

  always_comb begin
    v_in1 = 1'b0;
    d_in1 = '0;
    v_in2 = 1'b0;
    d_in2 = '0;
    v_c   = 1'b0;
    bit_c = cfg.const_data[0];
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (cfg.sel_1 == PC_SEL_W'(p)) begin
        v_in1 = din_v[p];
        d_in1 = din[p*DATA_WIDTH +: DATA_WIDTH];
      end
      if (cfg.sel_2 == PC_SEL_W'(p)) begin
        v_in2 = din_v[p];
        d_in2 = din[p*DATA_WIDTH +: DATA_WIDTH];
      end
      if (cfg.sel_c == PC_SEL_W'(p)) begin
        v_c   = din_v[p];
        bit_c = din[p*DATA_WIDTH];
      end
    end
  end

  assign push1 = !clear && sel1_port && v_in1 && !full1;
  assign push2 = !clear && sel2_port && !acc_mode && v_in2 && !full2;

  strela_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo_1 (
    .clk(clk), .rst(rst), .clear(!enable), .push(push1), .pop(fire && sel1_port),
    .din(d_in1), .dout(head1), .full(full1), .empty(empty1)
  );

  strela_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo_2 (
    .clk(clk), .rst(rst), .clear(!enable), .push(push2), .pop(fire && sel2_port && !acc_mode),
    .din(d_in2), .dout(head2), .full(full2), .empty(empty2)
  );

  assign op1   = sel1_port ? head1 : cfg.const_data;
  assign op1_v = !sel1_port || !empty1;

`ifdef STRELA_PC_ACC_EN
  logic [DATA_WIDTH-1:0] acc_q;
  assign acc_mode = cfg.acc;
  assign op2      = acc_mode ? acc_q : (sel2_port ? head2 : cfg.const_data);
  assign op2_v    = acc_mode || !sel2_port || !empty2;

  always_ff @(posedge clk) begin
    if (clear)                 acc_q <= cfg.initial_data;
    else if (fire && acc_mode) acc_q <= res;
  end
`else
  logic unused_acc;
  assign unused_acc = cfg.acc;
  assign acc_mode   = 1'b0;
  assign op2        = sel2_port ? head2 : cfg.const_data;
  assign op2_v      = !sel2_port || !empty2;
`endif

  // A constant-selected control path is always valid and never consumes.
  assign cin_v = !cfg.use_cin || !selc_port || v_c;
  assign cin   = cfg.use_cin && bit_c;

  always_comb begin
    res = op1;
    case (cfg.alu_op)
      ALU_ADD: res = op1 + op2;
      ALU_SUB: res = op1 - op2;
      ALU_MUL: res = op1 * op2;
      ALU_AND: res = op1 & op2;
      ALU_OR:  res = op1 | op2;
      ALU_XOR: res = op1 ^ op2;
      ALU_SLL: res = op1 << op2[SH_W-1:0];
      ALU_SRL: res = op1 >> op2[SH_W-1:0];
      ALU_SRA: res = $unsigned($signed(op1) >>> op2[SH_W-1:0]);
      ALU_LT:  res = {{(DATA_WIDTH-1){1'b0}}, ($signed(op1) < $signed(op2))};
      ALU_MUX: res = cin ? op1 : op2;
      default: res = op1;
    endcase
  end

  assign hs     = dout_v & dout_r;
  assign retire = out_valid && ((cfg.fork_mask & ~(sent | hs)) == '0);
  assign dout_v = {NUM_PORTS{out_valid}} & cfg.fork_mask & ~sent;
  assign dout   = out_data;

  // The token held in the output register already counts toward the limit,
  // so a retire-and-fire cycle cannot overshoot iter_count.
  assign in_flight = {1'b0, iter_cnt} + {{PC_ITER_W{1'b0}}, out_valid};
  assign done      = (cfg.iter_count != '0) && (iter_cnt >= cfg.iter_count);
  assign room      = (cfg.iter_count == '0) || (in_flight < {1'b0, cfg.iter_count});
  assign fire      = !clear && op1_v && op2_v && cin_v && !done && room && (!out_valid || retire);

  always_ff @(posedge clk) begin
    if (clear) begin
      out_valid <= cfg.initial_valid;
      out_data  <= cfg.initial_data;
      sent      <= '0;
      iter_cnt  <= '0;
    end else begin
      if (fire) begin
        out_valid <= 1'b1;
        out_data  <= res;
      end else if (retire) begin
        out_valid <= 1'b0;
      end
      sent <= retire ? '0 : (sent | hs);
      if (retire) iter_cnt <= iter_cnt + 1'b1;
    end
  end

  always_comb begin
    din_r = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (!clear)
        din_r[p] = ((cfg.sel_1 == PC_SEL_W'(p)) && !full1) ||
                   ((cfg.sel_2 == PC_SEL_W'(p)) && !acc_mode && !full2) ||
                   (cfg.use_cin && (cfg.sel_c == PC_SEL_W'(p)) && fire);
    end
  end

endmodule

// File: tb/tb_strela_pc_elastic.sv
// Bench for strela_pc_elastic: directed scenarios plus randomized rounds against a queue-based model.
// The accumulate scenario runs only when STRELA_PC_ACC_EN is defined.
module tb_strela_pc_elastic;
  import strela_pc_pkg::*;

  localparam int DW = 32;
  localparam int NP = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [NP*DW-1:0] din;
  logic [NP-1:0]  din_v, din_r, dout_v, dout_r;
  logic [DW-1:0]  dout;
  pc_cfg_t        cfg;
  logic           enable;
  logic           done;

  int n_checks = 0;
  int n_fail   = 0;

  strela_pc_elastic #(.DATA_WIDTH(DW), .NUM_PORTS(NP), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .din(din), .din_v(din_v), .din_r(din_r),
    .dout(dout), .dout_v(dout_v), .dout_r(dout_r),
    .cfg(cfg), .enable(enable), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic pc_cfg_t mk_cfg(input int s1, input int s2, input int sc, input bit uc,
                                     input alu_op_e op, input int mask, input bit acc,
                                     input bit iv, input logic [31:0] idata,
                                     input logic [31:0] cdata, input int iter);
    pc_cfg_t c;
    c = '0;
    c.sel_1 = PC_SEL_W'(s1);
    c.sel_2 = PC_SEL_W'(s2);
    c.sel_c = PC_SEL_W'(sc);
    c.use_cin = uc;
    c.alu_op = op;
    c.fork_mask = PC_NUM_PORTS'(mask);
    c.acc = acc;
    c.initial_valid = iv;
    c.initial_data = idata;
    c.const_data = cdata;
    c.iter_count = PC_ITER_W'(iter);
    return c;
  endfunction

  // Behavioural ALU straight from the opcode definitions.
  function automatic logic [31:0] ref_alu(input alu_op_e op, input logic [31:0] a,
                                          input logic [31:0] b, input logic c);
    int sh;
    logic [63:0] prod;
    sh = int'(b % 32);
    prod = 64'(a) * 64'(b);
    case (op)
      ALU_ADD: return a + b;
      ALU_SUB: return a - b;
      ALU_MUL: return prod[31:0];
      ALU_AND: return a & b;
      ALU_OR:  return a | b;
      ALU_XOR: return a ^ b;
      ALU_SLL: return a << sh;
      ALU_SRL: return a >> sh;
      ALU_SRA: return $unsigned($signed(a) >>> sh);
      ALU_LT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      ALU_MUX: return c ? a : b;
      default: return a;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_cfg(input pc_cfg_t c);
    rst = 1'b1;
    cfg = c;
    din_v = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  // Randomized-round model state
  bit            mon_on = 1'b0;
  int            m_s1, m_s2, m_sc;
  bit            m_uc;
  alu_op_e       m_op;
  logic [NP-1:0] m_mask;
  logic [31:0]   m_const;
  logic [31:0]   q1[$], q2[$], exp_q[$];
  logic          qc[$];
  int            recv[NP];

  always @(negedge clk) begin
    if (mon_on) begin
      logic [31:0] a, b;
      logic        c;
      if (din_v[m_s1] && din_r[m_s1]) q1.push_back(din[m_s1*DW +: DW]);
      if (m_s2 < NP && din_v[m_s2] && din_r[m_s2]) q2.push_back(din[m_s2*DW +: DW]);
      if (m_uc && din_v[m_sc] && din_r[m_sc]) qc.push_back(din[m_sc*DW]);
      while (q1.size() > 0 && (m_s2 >= NP || q2.size() > 0) && (!m_uc || qc.size() > 0)) begin
        a = q1.pop_front();
        b = (m_s2 >= NP) ? m_const : q2.pop_front();
        c = m_uc ? qc.pop_front() : 1'b0;
        exp_q.push_back(ref_alu(m_op, a, b, c));
      end
      for (int p = 0; p < NP; p++) begin
        if (dout_v[p] && dout_r[p]) begin
          if (recv[p] < exp_q.size()) check_eq("rand_data", 64'(dout), 64'(exp_q[recv[p]]));
          else check_eq("rand_extra_token", 64'(recv[p]), 64'(exp_q.size()));
          recv[p]++;
        end
      end
      check_eq("rand_unmasked_valid", 64'(dout_v & ~m_mask), 64'd0);
    end
  end

  initial begin
    int acc_n, out_n;
    logic in_hs;
    logic [31:0] acc_vals[$];
    logic [31:0] v;

    rst = 1'b1; enable = 1'b1; din = '0; din_v = '0; dout_r = '1;
    cfg = mk_cfg(0, NP, 0, 0, ALU_ADD, 4'b0010, 0, 0, 32'h0, 32'd5, 0);

    // Reset state and basic latency
    step(); step();
    @(negedge clk);
    check_eq("rst_din_r", 64'(din_r), 64'd0);
    check_eq("rst_dout_v", 64'(dout_v), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    step();
    rst = 1'b0;
    @(negedge clk);
    check_eq("din_r_after_rst", 64'(din_r), 64'b0001);
    step();
    din[0 +: DW] = 32'd7; din_v = 4'b0001;
    step();
    din_v = '0;
    @(negedge clk);
    check_eq("latency_1cyc_no_valid", 64'(dout_v), 64'd0);
    step();
    @(negedge clk);
    check_eq("latency_2cyc_valid", 64'(dout_v), 64'b0010);
    check_eq("add_const_data", 64'(dout), 64'd12);
    step();
    @(negedge clk);
    check_eq("token_retired", 64'(dout_v), 64'd0);

    // Eager fork with one branch stalled
    apply_cfg(mk_cfg(0, NP, 0, 0, ALU_ADD, 4'b0101, 0, 0, 32'h0, 32'd5, 0));
    dout_r = 4'b0001;
    din[0 +: DW] = 32'd1; din_v = 4'b0001;
    step();
    din[0 +: DW] = 32'd2;
    step();
    din_v = '0;
    @(negedge clk);
    check_eq("fork_first_valid", 64'(dout_v), 64'b0101);
    check_eq("fork_first_data", 64'(dout), 64'd6);
    for (int k = 0; k < 3; k++) begin
      step();
      @(negedge clk);
      check_eq("fork_hold_valid", 64'(dout_v), 64'b0100);
      check_eq("fork_hold_data", 64'(dout), 64'd6);
    end
    dout_r = 4'b0101;
    step();
    @(negedge clk);
    check_eq("fork_next_valid", 64'(dout_v), 64'b0101);
    check_eq("fork_next_data", 64'(dout), 64'd7);
    step();
    @(negedge clk);
    check_eq("fork_drained", 64'(dout_v), 64'd0);

    // Backpressure: FIFO plus output register hold three tokens
    apply_cfg(mk_cfg(0, NP, 0, 0, ALU_ADD, 4'b0010, 0, 0, 32'h0, 32'd5, 0));
    dout_r = '0;
    acc_n = 0; out_n = 0;
    din[0 +: DW] = 32'd10; din_v = 4'b0001;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge clk);
      if (cyc == 10) begin
        check_eq("bp_accepted", 64'(acc_n), 64'd3);
        check_eq("bp_din_r_low", 64'(din_r[0]), 64'd0);
        dout_r = 4'b0010;
      end
      in_hs = din_v[0] && din_r[0];
      if (dout_v[1] && dout_r[1]) begin
        check_eq("bp_data", 64'(dout), 64'(15 + out_n));
        out_n++;
      end
      step();
      if (in_hs) begin
        acc_n++;
        if (acc_n == 4) din_v = '0;
        else din[0 +: DW] = 32'(10 + acc_n);
      end
    end
    check_eq("bp_results", 64'(out_n), 64'd4);

    // Iteration limit
    apply_cfg(mk_cfg(0, NP, 0, 0, ALU_ADD, 4'b0010, 0, 0, 32'h0, 32'd5, 3));
    dout_r = '1;
    acc_n = 0; out_n = 0; acc_vals.delete();
    v = $urandom; din[0 +: DW] = v; din_v = 4'b0001;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      in_hs = din_v[0] && din_r[0];
      if (in_hs) acc_vals.push_back(din[0 +: DW]);
      if (dout_v[1] && dout_r[1]) begin
        if (out_n < acc_vals.size()) check_eq("iter_data", 64'(dout), 64'(acc_vals[out_n] + 32'd5));
        out_n++;
      end
      step();
      if (in_hs) begin
        acc_n++;
        v = $urandom; din[0 +: DW] = v;
      end
    end
    check_eq("iter_results", 64'(out_n), 64'd3);
    check_eq("iter_done", 64'(done), 64'd1);
    check_eq("iter_din_r_low", 64'(din_r[0]), 64'd0);
    check_eq("iter_accepted", 64'(acc_n), 64'd5);
    din_v = '0;

    // Enable-low clear with initial token
    apply_cfg(mk_cfg(0, NP, 0, 0, ALU_ADD, 4'b0011, 0, 1, 32'hA, 32'd5, 0));
    dout_r = '0;
    @(negedge clk);
    check_eq("init_valid_after_rst", 64'(dout_v), 64'b0011);
    check_eq("init_data_after_rst", 64'(dout), 64'hA);
    step();
    din[0 +: DW] = 32'd20; din_v = 4'b0001;
    step(); step(); step();
    din_v = '0; enable = 1'b0;
    step();
    enable = 1'b1;
    @(negedge clk);
    check_eq("clear_dout", 64'(dout), 64'hA);
    check_eq("clear_dout_v", 64'(dout_v), 64'b0011);
    check_eq("clear_fifo_ready", 64'(din_r[0]), 64'd1);
    dout_r = '1;
    step();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_eq("clear_flushed", 64'(dout_v), 64'd0);
      step();
    end

`ifdef STRELA_PC_ACC_EN
    // Accumulate mode: running sum of inputs
    apply_cfg(mk_cfg(0, 1, 0, 0, ALU_ADD, 4'b0010, 1, 0, 32'h0, 32'd0, 0));
    dout_r = '1;
    acc_n = 0; out_n = 0;
    v = 32'd0;
    din[0 +: DW] = 32'd1; din_v = 4'b0001;
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge clk);
      check_eq("acc_port2_not_ready", 64'(din_r[1]), 64'd0);
      in_hs = din_v[0] && din_r[0];
      if (dout_v[1] && dout_r[1]) begin
        v = v + 32'(out_n + 1);
        check_eq("acc_data", 64'(dout), 64'(v));
        out_n++;
      end
      step();
      if (in_hs) begin
        acc_n++;
        if (acc_n == 3) din_v = '0;
        else din[0 +: DW] = 32'(acc_n + 1);
      end
    end
    check_eq("acc_results", 64'(out_n), 64'd3);
`endif

    // Randomized rounds
    for (int r = 0; r < 6; r++) begin
      int rot;
      m_s1 = $urandom_range(0, NP-1);
      m_s2 = ($urandom_range(0, 1) == 1) ? NP : (m_s1 + 1 + $urandom_range(0, NP-2)) % NP;
      m_op = alu_op_e'($urandom_range(0, 11));
      if (r == 0) m_op = ALU_MUX;
      m_uc = (m_op == ALU_MUX) && (r == 0 || $urandom_range(0, 1) == 1);
      rot = $urandom_range(0, NP-1);
      m_sc = 0;
      for (int k = NP-1; k >= 0; k--) begin
        if (((k + rot) % NP) != m_s1 && ((k + rot) % NP) != m_s2) m_sc = (k + rot) % NP;
      end
      m_mask = NP'($urandom_range(1, 15));
      m_const = $urandom;
      q1.delete(); q2.delete(); qc.delete(); exp_q.delete();
      for (int p = 0; p < NP; p++) recv[p] = 0;
      apply_cfg(mk_cfg(m_s1, m_s2, m_sc, m_uc, m_op, int'(m_mask), 0, 0, 32'h0, m_const, 0));
      mon_on = 1'b1;
      for (int cyc = 0; cyc < 250; cyc++) begin
        for (int p = 0; p < NP; p++) begin
          v = $urandom;
          if (p == m_s2 && $urandom_range(0, 3) == 0) v = v & 32'h1F;
          din[p*DW +: DW] = v;
          din_v[p] = ($urandom_range(0, 9) < 6);
          dout_r[p] = ($urandom_range(0, 9) < 7);
        end
        step();
      end
      din_v = '0; dout_r = '1;
      repeat (20) step();
      mon_on = 1'b0;
      for (int p = 0; p < NP; p++) begin
        if (m_mask[p]) check_eq("rand_count", 64'(recv[p]), 64'(exp_q.size()));
      end
      check_eq("rand_progress", 64'(exp_q.size() > 0), 64'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
